// File: rtl/dma_copy.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dma_copy : single-channel word-copy bus initiator (one read, then its write)
// Optional fill mode compiled in with `define DMA_FILL_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module dma_copy #(
  parameter int RSP_TIMEOUT = 64,
  parameter int LEN_BITS    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LEN_BITS-1:0] len,
  input  logic                fill,
  input  logic [31:0]         fill_value,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_ready,
  output logic                mem_cmd_wr,
  output logic                mem_cmd_instr,
  output logic [31:0]         mem_cmd_addr,
  output logic [31:0]         mem_cmd_wdata,
  output logic [3:0]          mem_cmd_be,
  input  logic                mem_rsp_ready,
  input  logic [31:0]         mem_rsp_rdata
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT) + 1;
  // The increment that lands on RSP_TIMEOUT-1 is the abort point.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, DONE} state_t;

  state_t              state;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [LEN_BITS-1:0] remaining;
  logic [CNT_W-1:0]    cnt;
  logic                fill_mode;
  logic                start_fill;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^{src_addr[1:0], dst_addr[1:0]};
  assign mem_cmd_instr   = 1'b0;
  assign mem_cmd_be      = 4'hf;

`ifdef DMA_FILL_EN
  logic fill_q;
  assign fill_mode  = fill_q;
  assign start_fill = fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fill_q <= 1'b0;
    else if (state == IDLE && start)
      fill_q <= fill;
  end
`else
  logic unused_fill;
  assign fill_mode   = 1'b0;
  assign start_fill  = 1'b0;
  assign unused_fill = ^{fill, fill_value};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_wr    <= 1'b0;
      mem_cmd_addr  <= 32'd0;
      mem_cmd_wdata <= 32'd0;
      src           <= 32'd0;
      dst           <= 32'd0;
      remaining     <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src       <= {src_addr[31:2], 2'b00};
            dst       <= {dst_addr[31:2], 2'b00};
            remaining <= len;
            error     <= 1'b0;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= DONE;
            end else if (start_fill) begin
              state         <= WR_CMD;
              mem_cmd_valid <= 1'b1;
              mem_cmd_wr    <= 1'b1;
              mem_cmd_addr  <= {dst_addr[31:2], 2'b00};
              mem_cmd_wdata <= fill_value;
            end else begin
              state         <= RD_CMD;
              mem_cmd_valid <= 1'b1;
              mem_cmd_wr    <= 1'b0;
              mem_cmd_addr  <= {src_addr[31:2], 2'b00};
            end
          end
        end
        RD_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            cnt           <= '0;
            state         <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rsp_ready) begin
            mem_cmd_wdata <= mem_rsp_rdata;
            mem_cmd_valid <= 1'b1;
            mem_cmd_wr    <= 1'b1;
            mem_cmd_addr  <= dst;
            state         <= WR_CMD;
          end else if (cnt == CNT_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_CMD: begin
          if (mem_cmd_ready) begin
            src       <= src + 32'd4;
            dst       <= dst + 32'd4;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_BITS'(1)) begin
              mem_cmd_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= DONE;
            end else if (fill_mode) begin
              mem_cmd_addr <= dst + 32'd4;
            end else begin
              mem_cmd_wr   <= 1'b0;
              mem_cmd_addr <= src + 32'd4;
              state        <= RD_CMD;
            end
          end
        end
        DONE: begin
          // Zero-length starts arrive here with the pulse not yet raised.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_copy.sv
`default_nettype none
// tb_dma_copy: table-driven and randomized checks of dma_copy against a
// word-list reference model and a latency-programmable memory responder.
module tb_dma_copy;

  localparam int TMO    = 8;
  localparam int BUDGET = 2000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        fill;
  logic [31:0] fill_value;
  logic        busy, done, error;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr, mem_cmd_instr;
  logic [31:0] mem_cmd_addr, mem_cmd_wdata;
  logic [3:0]  mem_cmd_be;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;

  dma_copy #(.RSP_TIMEOUT(TMO), .LEN_BITS(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .fill(fill), .fill_value(fill_value),
    .busy(busy), .done(done), .error(error),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_wr(mem_cmd_wr), .mem_cmd_instr(mem_cmd_instr),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_cmd_be(mem_cmd_be),
    .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rq[$];
  logic [63:0] wq[$];
  int          lat      = 2;
  int          rdy_mode = 0;
  bit          noresp   = 0;
  bit          spur     = 0;
  bit          pend     = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr;
  bit          hv       = 0;
  logic [64:0] hold;

  function automatic void chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Memory responder: logs accepted commands, returns read data after lat cycles.
  initial begin
    mem_cmd_ready = 1'b1;
    mem_rsp_ready = 1'b0;
    mem_rsp_rdata = 32'd0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        if (hv) begin
          chk("hold_valid", 65'(mem_cmd_valid), 65'd1);
          chk("hold_cmd", {mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata}, hold);
        end
        hv   = mem_cmd_valid && !mem_cmd_ready;
        hold = {mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata};
        if (mem_cmd_valid && mem_cmd_ready) begin
          if (mem_cmd_wr) begin
            wq.push_back({mem_cmd_addr, mem_cmd_wdata});
          end else begin
            rq.push_back(mem_cmd_addr);
            pend      = 1;
            pend_cnt  = lat;
            pend_addr = mem_cmd_addr;
          end
        end
      end
      #1;
      mem_rsp_ready = 1'b0;
      mem_rsp_rdata = $urandom;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          pend = 0;
          if (!noresp) begin
            mem_rsp_ready = 1'b1;
            mem_rsp_rdata = memdata(pend_addr);
          end
        end
      end else if (spur && $urandom_range(3) == 0) begin
        mem_rsp_ready = 1'b1;
      end
      case (rdy_mode)
        0:       mem_cmd_ready = 1'b1;
        1:       mem_cmd_ready = ~mem_cmd_ready;
        default: mem_cmd_ready = 1'($urandom_range(1));
      endcase
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_busy"},  65'(busy), 65'd0);
    chk({tag, "_done"},  65'(done), 65'd0);
    chk({tag, "_error"}, 65'(error), 65'd0);
    chk({tag, "_valid"}, 65'(mem_cmd_valid), 65'd0);
    chk({tag, "_wr"},    65'(mem_cmd_wr), 65'd0);
    chk({tag, "_instr"}, 65'(mem_cmd_instr), 65'd0);
    chk({tag, "_addr"},  65'(mem_cmd_addr), 65'd0);
    chk({tag, "_wdata"}, 65'(mem_cmd_wdata), 65'd0);
    chk({tag, "_be"},    65'(mem_cmd_be), 65'hf);
  endtask

  // Start at cycle 0; returns the cycle index at which done is seen (-1 if never).
  task automatic do_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input logic f, input logic [31:0] fv, output int dc);
    rq.delete();
    wq.delete();
    src_addr = s; dst_addr = d; len = n; fill = f; fill_value = fv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = $urandom; dst_addr = $urandom; len = 16'($urandom);
    fill = 1'($urandom); fill_value = $urandom;
    dc = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      if (c == 1) begin
        chk("busy_c1", 65'(busy), 65'd1);
        chk("err_clr_c1", 65'(error), 65'd0);
        if (n != 0) chk("valid_c1", 65'(mem_cmd_valid), 65'd1);
      end
      if (done) begin
        dc = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (dc < 0) chk("done_seen", 65'd0, 65'd1);
    chk("busy_at_done", 65'(busy), 65'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 65'(done), 65'd0);
  endtask

  // Reference: word i reads src+4i and writes dst+4i (mod 2^32).
  task automatic check_model(input logic [31:0] s, input logic [31:0] d, input int n,
                             input bit fmode, input logic [31:0] fv, input bit nr);
    logic [31:0] sa, da, ea;
    int nrd, nwr;
    sa  = {s[31:2], 2'b00};
    da  = {d[31:2], 2'b00};
    nrd = fmode ? 0 : (nr ? 1 : n);
    nwr = nr ? 0 : n;
    chk("rd_count", 65'(rq.size()), 65'(nrd));
    chk("wr_count", 65'(wq.size()), 65'(nwr));
    for (int i = 0; i < n; i++) begin
      ea = sa + 32'(4 * i);
      if (i < nrd && i < rq.size()) chk("rd_addr", 65'(rq[i]), 65'(ea));
      if (i < nwr && i < wq.size())
        chk("wr_word", 65'(wq[i]), 65'({da + 32'(4 * i), fmode ? fv : memdata(ea)}));
    end
  endtask

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    logic [15:0] n;
    int          l;
    bit          nr;
    int          cyc;
    bit          err;
  } vec_t;

  vec_t tv[8];
  int   dc;
  bit   saw_done;
  logic [31:0] rs, rd;
  logic [15:0] rn;

  initial begin
    tv[0] = '{32'h0000_0100, 32'h0000_0200, 16'd4, 2, 1'b0, 17, 1'b0};
    tv[1] = '{32'h0000_0000, 32'h0000_0040, 16'd0, 2, 1'b0,  2, 1'b0};
    tv[2] = '{32'h0000_0007, 32'h0000_0013, 16'd1, 1, 1'b0,  4, 1'b0};
    tv[3] = '{32'hFFFF_FFF8, 32'h0000_1000, 16'd3, 1, 1'b0, 10, 1'b0};
    tv[4] = '{32'h0000_0300, 32'h0000_0400, 16'd3, 3, 1'b0, 16, 1'b0};
    tv[5] = '{32'h0000_0500, 32'h0000_0600, 16'd2, 2, 1'b1,  9, 1'b1};
    tv[6] = '{32'h0000_0020, 32'h0000_0030, 16'd1, 7, 1'b0, 10, 1'b0};
    tv[7] = '{32'h0000_0040, 32'h0000_0050, 16'd2, 5, 1'b0, 15, 1'b0};

    reset = 1'b1; start = 1'b0; src_addr = 0; dst_addr = 0; len = 0;
    fill = 0; fill_value = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      lat = tv[i].l; noresp = tv[i].nr; rdy_mode = 0; spur = 0;
      do_xfer(tv[i].s, tv[i].d, tv[i].n, 1'b0, 32'd0, dc);
      chk("done_cycle", 65'(dc), 65'(tv[i].cyc));
      chk("error_flag", 65'(error), 65'(tv[i].err));
      check_model(tv[i].s, tv[i].d, int'(tv[i].n), 1'b0, 32'd0, tv[i].nr);
    end
    noresp = 0;

    // Alternating ready: commands must hold while stalled.
    lat = 3; rdy_mode = 1;
    do_xfer(32'h0000_1000, 32'h0000_2000, 16'd5, 1'b0, 32'd0, dc);
    chk("toggle_error", 65'(error), 65'd0);
    check_model(32'h0000_1000, 32'h0000_2000, 5, 1'b0, 32'd0, 1'b0);

    // Random addresses, lengths, latencies, ready and stray responses.
    for (int k = 0; k < 12; k++) begin
      rs = $urandom; rd = $urandom; rn = 16'($urandom_range(1, 6));
      lat = $urandom_range(1, 6); rdy_mode = 2; spur = 1;
      do_xfer(rs, rd, rn, 1'b0, 32'd0, dc);
      chk("rand_error", 65'(error), 65'd0);
      check_model(rs, rd, int'(rn), 1'b0, 32'd0, 1'b0);
    end
    spur = 0; rdy_mode = 0;

    lat = 1;
`ifdef DMA_FILL_EN
    do_xfer(32'h0000_0040, 32'hFFFF_FFF8, 16'd3, 1'b1, 32'hDEAD_BEEF, dc);
    chk("fill_done_cycle", 65'(dc), 65'd4);
    check_model(32'h0000_0040, 32'hFFFF_FFF8, 3, 1'b1, 32'hDEAD_BEEF, 1'b0);
`else
    do_xfer(32'h0000_0040, 32'hFFFF_FFF8, 16'd3, 1'b1, 32'hDEAD_BEEF, dc);
    chk("nofill_done_cycle", 65'(dc), 65'd10);
    check_model(32'h0000_0040, 32'hFFFF_FFF8, 3, 1'b0, 32'd0, 1'b0);
`endif

    // Second start mid-transfer is ignored; reset during the write aborts.
    lat = 2; rdy_mode = 0; rq.delete(); wq.delete();
    src_addr = 32'h800; dst_addr = 32'h900; len = 16'd4; fill = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    src_addr = 32'hC00; dst_addr = 32'hD00; len = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid_wr_phase", 65'({mem_cmd_valid, mem_cmd_wr, mem_cmd_addr}), 65'({1'b1, 1'b1, 32'h900}));
    chk("mid_wr_data", 65'(mem_cmd_wdata), 65'(memdata(32'h800)));
    reset = 1'b1; pend = 0; hv = 0;
    #1;
    reset_vals("abort");
    saw_done = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done) saw_done = 1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 65'(saw_done), 65'd0);
    chk("abort_rd_count", 65'(rq.size()), 65'd1);
    chk("abort_rd_addr", 65'(rq.size() > 0 ? rq[0] : 32'hxxxx_xxxx), 65'(32'h800));
    chk("abort_wr_count", 65'(wq.size()), 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
